// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS-7 definitions for the GTX link-test RX checker and
// the TX generator.
//   - state_e              : checker FSM states (ST_HUNT, ST_LOCKED)
//   - DEF_*                : default lock/loss thresholds and LED stretch width
//   - prbs7_next_word(prev): next 16-bit word of the x^7+x^6+1 sequence.
//                            Bit 15 is the oldest bit and bit 0 the newest.
package prbs_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int unsigned DEF_LOCK_CNT  = 64;
  localparam int unsigned DEF_LOSS_ERRS = 8;
  localparam int unsigned DEF_STRETCH_W = 22;

  // b(n) = b(n-6) ^ b(n-7). Only prev[6:0] matter; they are the newest seven
  // serial bits, with prev[6] the oldest of them. The window keeps b(n-7) in
  // bit 6 and b(n-1) in bit 0.
  function automatic logic [15:0] prbs7_next_word(input logic [15:0] prev);
    logic [6:0]  s;
    logic [15:0] w;
    logic        nb;
    s = prev[6:0];
    w = '0;
    for (int i = 0; i < 16; i++) begin
      nb = s[6] ^ s[5];
      s  = {s[5:0], nb};
      w  = {w[14:0], nb};
    end
    return w;
  endfunction

endpackage

// File: rtl/led_stretch.sv
// led_stretch: stretches a one-cycle trigger into a visible LED pulse.
//   clk160  : clock
//   reset_n : async active-low reset
//   trig    : reloads the stretch counter to all-ones
//   led     : high while the trigger is present or the counter is non-zero.
//             The pulse lasts 2^STRETCH_W cycles from the trigger cycle.
module led_stretch
  import prbs_pkg::*;
#(
  parameter int unsigned STRETCH_W = DEF_STRETCH_W
) (
  input  logic clk160,
  input  logic reset_n,
  input  logic trig,
  output logic led
);

  logic [STRETCH_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trig)              cnt_d = '1;
    else if (cnt_q != '0)  cnt_d = cnt_q - STRETCH_W'(1);
  end

  always_ff @(posedge clk160 or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // The trigger cycle is included so the LED rises together with the error
  // flag. The counter then covers the remaining 2^STRETCH_W - 1 cycles.
  assign led = trig | (cnt_q != '0);

endmodule

// File: rtl/prbs7_rx_checker.sv
// prbs7_rx_checker: per-lane PRBS-7 receive checker.
//   clk160     : RX user clock
//   reset_n    : async active-low reset
//   rx_data    : received word (bit 15 oldest serial bit)
//   rx_valid   : rx_data qualifier
//   clear      : sync clear of err_count / word_count
//   locked     : checker is in LOCKED
//   word_err   : one-cycle flag, last checked word (LOCKED) had bit errors
//   err_count  : saturating bit-error total
//   word_count : saturating count of words checked while LOCKED
//   led_lock   : equals locked
//   led_err    : pulse-stretched word_err
// Pipeline: stage 1 captures the word plus its expected value. Stage 2
// compares the two and registers every output. A word therefore shows up on
// the outputs two cycles after it is presented.
module prbs7_rx_checker
  import prbs_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned LOCK_CNT  = DEF_LOCK_CNT,
  parameter int unsigned LOSS_ERRS = DEF_LOSS_ERRS,
  parameter int unsigned STRETCH_W = DEF_STRETCH_W
) (
  input  logic              clk160,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              clear,
  output logic              locked,
  output logic              word_err,
  output logic [31:0]       err_count,
  output logic [31:0]       word_count,
  output logic              led_lock,
  output logic              led_err
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(LOSS_ERRS + 1);

  // stage 1
  logic [DATA_W-1:0] data_s1_q, exp_s1_q, pred_q;
  logic              vld_s1_q;

  // stage 2 / FSM
  state_e            state_q;
  logic [GW-1:0]     good_q;
  logic [BW-1:0]     bad_q;
  logic              word_err_q;
  logic [31:0]       err_q, wc_q;

  logic [DATA_W-1:0] mism;
  logic [4:0]        pop;
  logic              hit, lock_evt, loss_evt, locked_nxt;
  logic [32:0]       err_sum;
  logic [31:0]       err_d, wc_d;

  always_comb begin
    mism     = data_s1_q ^ exp_s1_q;
    pop      = 5'($countones(mism));
    hit      = (mism == '0);
    lock_evt = vld_s1_q && (state_q == ST_HUNT) && hit
               && (good_q == GW'(LOCK_CNT - 1));
    loss_evt = vld_s1_q && (state_q == ST_LOCKED) && !hit
               && (bad_q == BW'(LOSS_ERRS - 1));
    locked_nxt = (state_q == ST_LOCKED) ? !loss_evt : lock_evt;
    err_sum  = {1'b0, err_q} + {28'b0, pop};
    err_d    = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    wc_d     = (wc_q == 32'hFFFF_FFFF) ? wc_q : wc_q + 32'd1;
  end

  // The predictor mode follows the state that will hold once the word now in
  // stage 2 has been judged. The word entering stage 1 comes right after that
  // word, so a lock or loss decided this cycle already applies to it.
  always_ff @(posedge clk160 or negedge reset_n) begin
    if (!reset_n) begin
      data_s1_q <= '0;
      exp_s1_q  <= '0;
      pred_q    <= '0;
      vld_s1_q  <= 1'b0;
    end else begin
      vld_s1_q <= rx_valid;
      if (rx_valid) begin
        data_s1_q <= rx_data;
        exp_s1_q  <= pred_q;
        pred_q    <= prbs7_next_word(locked_nxt ? pred_q : rx_data);
      end
    end
  end

  always_ff @(posedge clk160 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HUNT;
      good_q     <= '0;
      bad_q      <= '0;
      word_err_q <= 1'b0;
      err_q      <= '0;
      wc_q       <= '0;
    end else begin
      word_err_q <= 1'b0;
      if (vld_s1_q) begin
        case (state_q)
          ST_HUNT: begin
            if (!hit)          good_q <= '0;
            else if (lock_evt) begin
              state_q <= ST_LOCKED;
              good_q  <= '0;
              bad_q   <= '0;
            end else           good_q <= good_q + GW'(1);
          end
          ST_LOCKED: begin
            word_err_q <= !hit;
            if (hit)           bad_q <= '0;
            else if (loss_evt) begin
              state_q <= ST_HUNT;
              good_q  <= '0;
              bad_q   <= '0;
            end else           bad_q <= bad_q + BW'(1);
          end
          default: state_q <= ST_HUNT;
        endcase
      end
      // A clear in the same cycle as an error drops that error.
      if (clear) begin
        err_q <= '0;
        wc_q  <= '0;
      end else if (vld_s1_q && state_q == ST_LOCKED) begin
        err_q <= err_d;
        wc_q  <= wc_d;
      end
    end
  end

  led_stretch #(.STRETCH_W(STRETCH_W)) u_err_led (
    .clk160  (clk160),
    .reset_n (reset_n),
    .trig    (word_err_q),
    .led     (led_err)
  );

  assign locked     = (state_q == ST_LOCKED);
  assign led_lock   = locked;
  assign word_err   = word_err_q;
  assign err_count  = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_prbs7_rx_checker.sv
module tb_prbs7_rx_checker;
  localparam int LOCK_CNT  = 64;
  localparam int LOSS_ERRS = 8;
  localparam int STRETCH_W = 4;

  logic        clk160 = 1'b0, reset_n = 1'b0, rx_valid = 1'b0, clear = 1'b0;
  logic [15:0] rx_data = '0;
  logic        locked, word_err, led_lock, led_err;
  logic [31:0] err_count, word_count;

  always #5 clk160 = ~clk160;

  prbs7_rx_checker #(.DATA_W(16), .LOCK_CNT(LOCK_CNT), .LOSS_ERRS(LOSS_ERRS),
                     .STRETCH_W(STRETCH_W)) dut (
    .clk160(clk160), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear(clear), .locked(locked), .word_err(word_err), .err_count(err_count),
    .word_count(word_count), .led_lock(led_lock), .led_err(led_err));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial reference: extend the bit history with b(n)=b(n-6)^b(n-7).
  function automatic logic [15:0] ref_next(input logic [15:0] prev);
    bit h[$];
    logic [15:0] r;
    for (int i = 6; i >= 0; i--) h.push_back(prev[i]);
    for (int j = 0; j < 16; j++) h.push_back(h[h.size()-6] ^ h[h.size()-7]);
    for (int j = 0; j < 16; j++) r[15-j] = h[7+j];
    return r;
  endfunction

  logic [15:0] gen_last;
  task automatic gen_word(output logic [15:0] w);
    w = ref_next(gen_last);
    gen_last = w;
  endtask

  // Word-level model of the checker, plus a one-word pipeline holding slot
  bit          m_locked, m_werr, p_v, prev_lock_obs;
  int          m_good, m_bad, m_age, n_valid, lock_vcnt;
  logic [15:0] m_pred, p_d;
  logic [31:0] m_err, m_wc;

  task automatic m_reset();
    m_locked = 0; m_werr = 0; p_v = 0; m_good = 0; m_bad = 0; m_age = 1000;
    m_pred = '0; p_d = '0; m_err = '0; m_wc = '0; prev_lock_obs = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_werr"}, word_err, 0);
    chk({tag, "_errcnt"}, err_count, 0);
    chk({tag, "_wcnt"}, word_count, 0);
    chk({tag, "_ledlock"}, led_lock, 0);
    chk({tag, "_lederr"}, led_err, 0);
  endtask

  // One clock: drive inputs, then after the edge evaluate the model for the
  // word sampled on the previous edge and compare all outputs.
  task automatic cyc(input bit v, input logic [15:0] d, input bit clr);
    logic [15:0] e;
    int nb;
    longint s;
    rx_valid = v; rx_data = d; clear = clr;
    @(posedge clk160); #1;
    m_werr = 0;
    if (p_v) begin
      e  = m_pred;
      nb = $countones(p_d ^ e);
      if (m_locked) begin
        m_werr = (nb != 0);
        s = longint'(m_err) + nb;
        m_err = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
        if (m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 1;
        if (nb != 0) m_bad++; else m_bad = 0;
        if (m_bad == LOSS_ERRS) begin m_locked = 0; m_bad = 0; m_good = 0; end
      end else begin
        if (nb == 0) m_good++; else m_good = 0;
        if (m_good == LOCK_CNT) begin m_locked = 1; m_good = 0; m_bad = 0; end
      end
      m_pred = ref_next(m_locked ? e : p_d);
    end
    if (clr) begin m_err = 0; m_wc = 0; end
    if (m_werr) m_age = 0; else if (m_age < 1000) m_age++;
    chk("locked", locked, m_locked);
    chk("word_err", word_err, m_werr);
    chk("err_count", err_count, m_err);
    chk("word_count", word_count, m_wc);
    chk("led_lock", led_lock, m_locked);
    chk("led_err", led_err, m_age < (1 << STRETCH_W));
    if (locked && !prev_lock_obs) lock_vcnt = n_valid;
    prev_lock_obs = locked;
    p_v = v; p_d = d;
    if (v) n_valid++;
  endtask

  initial begin
    logic [15:0] w;
    int base, zsum, werr_cnt, led_cnt;
    n_valid = 0; lock_vcnt = -1;
    m_reset();

    // reset held with garbage on the inputs
    reset_n = 0;
    repeat (4) begin
      rx_data = 16'($urandom); rx_valid = 1'($urandom);
      @(posedge clk160); #1;
      chk_zero("rst");
    end
    @(negedge clk160); reset_n = 1; rx_valid = 0;
    repeat (5) cyc(0, 16'($urandom), 0);

    // clean acquisition from seed 7F
    gen_last = 16'h007F; base = n_valid; lock_vcnt = -1;
    repeat (80) begin gen_word(w); cyc(1, w, 0); end
    chk("acq_lock_words", lock_vcnt - base, 65);
    chk("acq_errcnt", err_count, 0);
    chk("acq_wcnt", word_count, 14);

    // single-bit error on bit 3
    gen_word(w); cyc(1, w ^ 16'h0008, 0);
    werr_cnt = 0; led_cnt = 0;
    repeat (20) begin
      gen_word(w); cyc(1, w, 0);
      werr_cnt += int'(word_err); led_cnt += int'(led_err);
    end
    chk("bit_errcnt", err_count, 1);
    chk("bit_werr_cycles", werr_cnt, 1);
    chk("bit_led_cycles", led_cnt, 16);
    chk("bit_locked", locked, 1);

    // loss of lock: eight all-zero words
    zsum = 0;
    repeat (LOSS_ERRS) begin gen_word(w); zsum += $countones(w); cyc(1, 16'h0000, 0); end
    chk("loss_still_locked", locked, 1);
    gen_last = 16'h007F; base = n_valid; lock_vcnt = -1;
    for (int i = 0; i < 80; i++) begin
      gen_word(w); cyc(1, w, 0);
      if (i == 0) begin
        chk("loss_locked", locked, 0);
        chk("loss_errcnt", err_count, 1 + zsum);
      end
    end
    chk("relock_words", lock_vcnt - base, 65);

    // clear in the same cycle as a 2-bit error
    gen_word(w); cyc(1, w ^ 16'h0201, 0);
    gen_word(w); cyc(1, w, 1);
    chk("clr_errcnt", err_count, 0);
    chk("clr_wcnt", word_count, 0);
    repeat (5) begin gen_word(w); cyc(1, w, 0); end
    chk("clr_after_errcnt", err_count, 0);
    chk("clr_after_wcnt", word_count, 5);

    // async reset pulse while locked
    chk("pre_rst_locked", locked, 1);
    #2 reset_n = 0;
    #1 chk_zero("arst");
    repeat (3) begin rx_data = 16'($urandom); rx_valid = 1'($urandom); @(posedge clk160); end
    m_reset();
    @(negedge clk160); reset_n = 1;

    // acquisition with every other cycle idle
    gen_last = 16'(7'($urandom_range(1, 127))); base = n_valid; lock_vcnt = -1;
    for (int i = 0; i < 160; i++) begin
      if (i % 2 == 1) begin gen_word(w); cyc(1, w, 0); end
      else cyc(0, 16'($urandom), 0);
    end
    chk("gap_lock_words", lock_vcnt - base, 65);
    chk("gap_errcnt", err_count, 0);

    // random traffic: gaps, sparse bit flips, clears, one junk burst
    for (int i = 0; i < 400; i++) begin
      if (i >= 150 && i < 162) cyc(1, 16'($urandom), 0);
      else if ($urandom_range(0, 2) != 0) begin
        gen_word(w);
        if ($urandom_range(0, 15) == 0) w = w ^ (16'h1 << $urandom_range(0, 15));
        cyc(1, w, $urandom_range(0, 40) == 0);
      end else cyc(0, 16'($urandom), $urandom_range(0, 40) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
